// File: rtl/matmul_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matmul_ctrl_if                                                       |
// | Decoder, data-memory and FPU signals seen by the MATMUL.FP sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface matmul_ctrl_if #(
    parameter int AW = 32
);
    logic          MatmulStart;
    logic [AW-1:0] BaseA;
    logic [AW-1:0] BaseB;
    logic [AW-1:0] BaseC;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] MemAddr;
    logic          MemRead;
    logic          MemWrite;
    logic [31:0]   MemWData;
    logic [31:0]   MemRData;
    logic          FPUStart;
    logic [2:0]    FPUControl;
    logic [31:0]   FPUSrcA;
    logic [31:0]   FPUSrcB;
    logic [31:0]   FPUResult;
    logic          FPUDone;

    modport master (
        input  MatmulStart, BaseA, BaseB, BaseC, MemRData, FPUResult, FPUDone,
        output Busy, Done, MemAddr, MemRead, MemWrite, MemWData,
               FPUStart, FPUControl, FPUSrcA, FPUSrcB
    );

    modport slave (
        output MatmulStart, BaseA, BaseB, BaseC, MemRData, FPUResult, FPUDone,
        input  Busy, Done, MemAddr, MemRead, MemWrite, MemWData,
               FPUStart, FPUControl, FPUSrcA, FPUSrcB
    );
endinterface
`default_nettype wire

// File: rtl/matmul_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matmul_ctrl                                                          |
// | Sequences C = A x B (N x N, fp32, row-major) over memory and the FPU |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module matmul_ctrl #(
    parameter int N  = 2,
    parameter int AW = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    matmul_ctrl_if.master bus
);
    localparam int                 c_iw     = $clog2(N);
    localparam logic [c_iw-1:0]    c_last   = c_iw'(N - 1);
    localparam logic [2:0]         c_op_add = 3'b000;
    localparam logic [2:0]         c_op_mul = 3'b010;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RDA  = 4'd1,
        S_RDB  = 4'd2,
        S_MUL  = 4'd3,
        S_MULW = 4'd4,
        S_ADD  = 4'd5,
        S_ADDW = 4'd6,
        S_WR   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_base_a;
    logic [AW-1:0]     r_base_b;
    logic [AW-1:0]     r_base_c;
    logic [c_iw-1:0]   r_i;
    logic [c_iw-1:0]   r_j;
    logic [c_iw-1:0]   r_k;
    logic [31:0]       r_acc;
    logic              r_busy;
    logic              r_done;
    logic [AW-1:0]     r_memaddr;
    logic              r_memread;
    logic              r_memwrite;
    logic [31:0]       r_memwdata;
    logic              r_fpustart;
    logic [2:0]        r_fpuctl;
    // The FPU source registers double as opA/opB during FMUL and acc/prod during FADD.
    logic [31:0]       r_srca;
    logic [31:0]       r_srcb;

    function automatic logic [AW-1:0] f_off(input logic [c_iw-1:0] row,
                                            input logic [c_iw-1:0] col);
        logic [AW-1:0] t;
        t = AW'(row) * AW'(N) + AW'(col);
        return t << 2;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_c   <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_memaddr  <= '0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memwdata <= '0;
            r_fpustart <= 1'b0;
            r_fpuctl   <= c_op_add;
            r_srca     <= '0;
            r_srcb     <= '0;
        end else begin
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_fpustart <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.MatmulStart) begin
                        r_base_a  <= bus.BaseA;
                        r_base_b  <= bus.BaseB;
                        r_base_c  <= bus.BaseC;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_k       <= '0;
                        r_acc     <= '0;
                        r_busy    <= 1'b1;
                        r_memread <= 1'b1;
                        r_memaddr <= bus.BaseA;
                        r_state   <= S_RDA;
                    end
                end
                S_RDA: begin
                    r_memread <= 1'b1;
                    r_memaddr <= r_base_b + f_off(r_k, r_j);
                    r_state   <= S_RDB;
                end
                S_RDB: begin
                    r_srca     <= bus.MemRData;
                    r_fpustart <= 1'b1;
                    r_fpuctl   <= c_op_mul;
                    r_state    <= S_MUL;
                end
                S_MUL: begin
                    r_srcb  <= bus.MemRData;
                    r_state <= S_MULW;
                end
                S_MULW: begin
                    if (bus.FPUDone) begin
                        r_srca     <= r_acc;
                        r_srcb     <= bus.FPUResult;
                        r_fpustart <= 1'b1;
                        r_fpuctl   <= c_op_add;
                        r_state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_state <= S_ADDW;
                end
                S_ADDW: begin
                    if (bus.FPUDone) begin
                        r_acc <= bus.FPUResult;
                        if (r_k == c_last) begin
                            r_memwrite <= 1'b1;
                            r_memaddr  <= r_base_c + f_off(r_i, r_j);
                            r_memwdata <= bus.FPUResult;
                            r_state    <= S_WR;
                        end else begin
                            r_k       <= r_k + c_iw'(1);
                            r_memread <= 1'b1;
                            r_memaddr <= r_base_a + f_off(r_i, r_k + c_iw'(1));
                            r_state   <= S_RDA;
                        end
                    end
                end
                S_WR: begin
                    r_k   <= '0;
                    r_acc <= '0;
                    if (r_j != c_last) begin
                        r_j       <= r_j + c_iw'(1);
                        r_memread <= 1'b1;
                        r_memaddr <= r_base_a + f_off(r_i, '0);
                        r_state   <= S_RDA;
                    end else if (r_i != c_last) begin
                        r_j       <= '0;
                        r_i       <= r_i + c_iw'(1);
                        r_memread <= 1'b1;
                        r_memaddr <= r_base_a + f_off(r_i + c_iw'(1), '0);
                        r_state   <= S_RDA;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy       = r_busy;
    assign bus.Done       = r_done;
    assign bus.MemAddr    = r_memaddr;
    assign bus.MemRead    = r_memread;
    assign bus.MemWrite   = r_memwrite;
    assign bus.MemWData   = r_memwdata;
    assign bus.FPUStart   = r_fpustart;
    assign bus.FPUControl = r_fpuctl;
    assign bus.FPUSrcA    = r_srca;
    // B arrives from memory in the FMUL issue cycle itself, so it bypasses the register once.
    assign bus.FPUSrcB    = (r_state == S_MUL) ? bus.MemRData : r_srcb;
endmodule
`default_nettype wire
